// File: rtl/decoder_scan_if.sv
// Control/status bundle between a scan controller and the decoder scan sequencer.
interface decoder_scan_if;
  logic        start;
  logic        stop;
  logic        continuous;
  logic [15:0] line_mask;
  logic [3:0]  sel;
  logic        enable_n;
  logic        sample;
  logic        done;
  logic        busy;

  modport master (
    output start, stop, continuous, line_mask,
    input  sel, enable_n, sample, done, busy
  );

  modport slave (
    input  start, stop, continuous, line_mask,
    output sel, enable_n, sample, done, busy
  );
endinterface

// File: rtl/decoder_scan_sequencer.sv
// Sweeps a 4-to-16 active-low decoder through a masked subset of lines with
// per-line dwell, optional blanking gaps, sample strobes and end-of-sweep pulses.
module decoder_scan_sequencer #(
  parameter int DWELL = 4,
  parameter int GAP   = 1
) (
  input  logic           clk,
  input  logic           reset,
  decoder_scan_if.slave  bus
);

  localparam int DW = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam int GW = (GAP > 1) ? $clog2(GAP) : 1;
  localparam logic [DW-1:0] DWELL_LD = DW'(DWELL - 1);
  localparam logic [GW-1:0] GAP_LD   = GW'((GAP > 0) ? GAP - 1 : 0);

  typedef enum logic [1:0] {S_IDLE, S_DRIVE, S_GAP} state_e;

  state_e        state_q, state_d;
  logic [3:0]    sel_q, sel_d, pend_q, pend_d;
  logic [DW-1:0] dwell_q, dwell_d;
  logic [GW-1:0] gap_q, gap_d;
  logic [15:0]   mask_q, mask_d;
  logic          en_n_q, sample_q, done_q, busy_q;
  logic          sample_d, done_d;

  // {found, index} of the lowest set bit of m at or above 'from' (from=16 finds nothing)
  function automatic logic [4:0] first_from(input logic [15:0] m, input logic [4:0] from);
    logic [4:0] r;
    r = '0;
    for (int i = 15; i >= 0; i--)
      if (m[i] && (5'(i) >= from)) r = {1'b1, 4'(i)};
    return r;
  endfunction

  logic [4:0] nxt, wrap, after_d;
  logic       go;
  logic [3:0] tgt;

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    pend_d  = pend_q;
    dwell_d = dwell_q;
    gap_d   = gap_q;
    mask_d  = mask_q;
    go      = 1'b0;
    tgt     = '0;
    nxt     = first_from(mask_q, {1'b0, sel_q} + 5'd1);
    wrap    = first_from(bus.line_mask, 5'd0);

    case (state_q)
      S_IDLE: begin
        if (bus.start && !bus.stop && (bus.line_mask != '0)) begin
          mask_d  = bus.line_mask;
          sel_d   = wrap[3:0];
          dwell_d = DWELL_LD;
          state_d = S_DRIVE;
        end
      end
      S_DRIVE: begin
        if (bus.stop) begin
          state_d = S_IDLE;
        end else if (dwell_q != '0) begin
          dwell_d = dwell_q - 1'b1;
        end else begin
          if (nxt[4]) begin
            go  = 1'b1;
            tgt = nxt[3:0];
          end else if (bus.continuous) begin
            // wrap re-captures the mask; an empty mask ends the run
            mask_d = bus.line_mask;
            go     = wrap[4];
            tgt    = wrap[3:0];
          end
          if (!go) begin
            state_d = S_IDLE;
          end else if (GAP > 0) begin
            state_d = S_GAP;
            gap_d   = GAP_LD;
            pend_d  = tgt;
          end else begin
            sel_d   = tgt;
            dwell_d = DWELL_LD;
          end
        end
      end
      S_GAP: begin
        if (bus.stop) begin
          state_d = S_IDLE;
        end else if (gap_q == '0) begin
          sel_d   = pend_q;
          dwell_d = DWELL_LD;
          state_d = S_DRIVE;
        end else begin
          gap_d = gap_q - 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // strobes are decided one edge early so they line up with the last dwell cycle
    after_d  = first_from(mask_d, {1'b0, sel_d} + 5'd1);
    sample_d = (state_d == S_DRIVE) && (dwell_d == '0);
    done_d   = sample_d && !after_d[4];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      sel_q    <= '0;
      pend_q   <= '0;
      dwell_q  <= '0;
      gap_q    <= '0;
      mask_q   <= '0;
      en_n_q   <= 1'b1;
      sample_q <= 1'b0;
      done_q   <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      sel_q    <= sel_d;
      pend_q   <= pend_d;
      dwell_q  <= dwell_d;
      gap_q    <= gap_d;
      mask_q   <= mask_d;
      en_n_q   <= (state_d != S_DRIVE);
      sample_q <= sample_d;
      done_q   <= done_d;
      busy_q   <= (state_d != S_IDLE);
    end
  end

  assign bus.sel      = sel_q;
  assign bus.enable_n = en_n_q;
  assign bus.sample   = sample_q;
  assign bus.done     = done_q;
  assign bus.busy     = busy_q;

endmodule

// File: doc/decoder_scan_sequencer.md
Name: decoder_scan_sequencer

Overview:
Sequencer that drives the select and active-low enable inputs of the 4-to-16 active-low decoder. It sweeps the decoder through a programmable subset of its 16 lines. Each selected line is held for a fixed dwell time, with optional blanking gaps between lines. It emits a per-line sample strobe and an end-of-sweep pulse, so a downstream column/sense stage can capture data while each line is driven. Used for keypad and LED-matrix row scanning.

Parameters:
DWELL, 4, cycles enable_n is held low per line; legal range >= 1
GAP, 1, blank cycles (enable_n high) between consecutive lines; legal range >= 0

Ports:
clk  input  1  single clock, rising edge
reset  input  1  synchronous, active-high
start  input  1  begin a sweep; level sampled each cycle, honoured only in IDLE
stop  input  1  abort the current sweep
continuous  input  1  1 = wrap and repeat sweeps, 0 = single sweep
line_mask  input  16  1 = line included in sweep; bit i = decoder line i
sel  output  4  decoder select (feeds decoder in[3:0])
enable_n  output  1  decoder enable, active low (feeds decoder enable)
sample  output  1  one-cycle strobe on the last dwell cycle of each line
done  output  1  one-cycle pulse on the last dwell cycle of the final line of a sweep
busy  output  1  high whenever state != IDLE

Behaviour:
- Reset (sync, active-high) values: sel=0, enable_n=1, sample=0, done=0, busy=0, state=IDLE, counters=0. Reset asserted mid-sweep has the same effect at the next edge. No partial line completes and no sample or done is issued.
- All outputs are registered.
- States: IDLE, DRIVE, GAP.
- IDLE: enable_n=1; sel holds its last value.
  - If start=1, stop=0 and line_mask!=0: latch line_mask into mask_q, load sel = lowest set bit of line_mask, load dwell counter = DWELL-1, go to DRIVE.
  - If start=1 and line_mask=0: stay in IDLE; no done.
  - If start and stop are both 1: stop wins; stay in IDLE.
- DRIVE: enable_n=0; the dwell counter decrements each cycle.
  - When dwell count = 0: sample=1 this cycle. Next line = lowest set bit of mask_q strictly above sel.
    - If a next line exists: if GAP>0, go to GAP with the gap counter = GAP-1; otherwise stay in DRIVE with sel = next line and the dwell counter reloaded (back-to-back lines, enable_n stays low).
    - If no next line exists (end of sweep): done=1 in the same cycle as sample.
      - If continuous=1: re-latch mask_q from line_mask. If the new mask is nonzero, wrap to its lowest set bit, going through GAP if GAP>0. If the new mask is zero, go to IDLE.
      - If continuous=0: go to IDLE.
- GAP: enable_n=1; sel holds the previous line. When the gap counter reaches 0, load sel = pending next line, reload the dwell counter, go to DRIVE.
- Latency: start sampled at edge N gives enable_n=0 with the first line from cycle N+1.
- Line timing: each line occupies DWELL cycles, plus GAP cycles before the next line.
- Mask rule: mask_q is captured only at sweep start or at wrap. Changes to line_mask mid-sweep have no effect until the next capture.
- stop (any non-IDLE state): at the next edge go to IDLE with enable_n=1 and busy=0. No sample or done is issued for the aborted line. If stop coincides with a sample cycle, that cycle's sample/done still appear, since they are already registered.
- start while busy: ignored.
- Single-line mask (e.g. 16'h0001) with continuous=1 and GAP=0: the same line repeats, enable_n stays low, and sample and done pulse every DWELL cycles.
- Wrap-around: index search never exceeds 15; the end of sweep is determined by the absence of a higher set bit, never by counter overflow.

Test Plan:
1. Assert reset mid-sweep (DWELL=2, GAP=1, mask=16'hFFFF) -> next cycle sel=0, enable_n=1, busy=0, sample=0, done=0; outputs stay idle until start.
2. DWELL=2, GAP=1, mask=16'h0005, continuous=0, start pulse at cycle 0:
   - cycles 1-2: sel=0, enable_n=0; sample=1 at cycle 2.
   - cycle 3: enable_n=1, sel=0.
   - cycles 4-5: sel=2, enable_n=0; sample=1 and done=1 at cycle 5.
   - cycle 6: busy=0.
3. DWELL=2, GAP=1, mask=16'h8001, continuous=1 -> sel sequence 0,0,gap,15,15(done),gap,0,0,... repeating; at most one done per 6 cycles.
4. stop=1 during the first dwell cycle of line 3 (mask=16'h0008) -> next cycle enable_n=1, busy=0; sample and done never assert.
5. start with mask=0 -> busy stays 0, enable_n=1. Then start with mask=16'h0010 and change line_mask to 16'h0001 mid-dwell -> sweep still drives only sel=4.
6. DWELL=2, GAP=0, mask=16'hFFFF, continuous=0 -> enable_n low for 32 consecutive cycles; sel increments 0..15 every 2 cycles; 16 sample pulses; done only on the 32nd cycle.
